// File: rtl/signed_sub_with_overflow_serial.sv
// signed_sub_with_overflow_serial: bit-serial two's-complement a - b with signed overflow, valid/ready handshakes
module signed_sub_with_overflow_serial #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             up_valid,
    output logic             up_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             down_valid,
    input  logic             down_ready,
    output logic [WIDTH-1:0] diff,
    output logic             overflow
);
    localparam int CW = $clog2(WIDTH);
    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
    state_t           state;
    logic [WIDTH-1:0] a_r;
    logic [WIDTH-1:0] nb_r;
    logic             carry;
    logic [CW-1:0]    cnt;
    logic             sum_bit;
    logic             cout;
    assign sum_bit = a_r[0] ^ nb_r[0] ^ carry;
    assign cout    = (a_r[0] & nb_r[0]) | (a_r[0] & carry) | (nb_r[0] & carry);
    // a_r doubles as the result shift register: difference bits enter at the MSB as operand bits leave the LSB
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            a_r        <= '0;
            nb_r       <= '0;
            carry      <= 1'b0;
            cnt        <= '0;
            up_ready   <= 1'b1;
            down_valid <= 1'b0;
            diff       <= '0;
            overflow   <= 1'b0;
        end else begin
            case (state)
                IDLE: if (up_valid) begin
                    a_r      <= a;
                    nb_r     <= ~b;
                    carry    <= 1'b1;
                    cnt      <= '0;
                    up_ready <= 1'b0;
                    state    <= CALC;
                end
                CALC: begin
                    a_r   <= {sum_bit, a_r[WIDTH-1:1]};
                    nb_r  <= {1'b0, nb_r[WIDTH-1:1]};
                    carry <= cout;
                    cnt   <= cnt + 1'b1;
                    if (cnt == CW'(WIDTH - 1)) begin
                        diff       <= {sum_bit, a_r[WIDTH-1:1]};
                        overflow   <= carry ^ cout;
                        down_valid <= 1'b1;
                        cnt        <= '0;
                        state      <= DONE;
                    end
                end
                DONE: if (down_ready) begin
                    down_valid <= 1'b0;
                    up_ready   <= 1'b1;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
